// File: rtl/rv32_pkg.sv
// Shared RV32 decode encodings used by the decoder and the ID/EX pipeline register.
package rv32_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Writeback result source select
    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    // Load widths
    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_W  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;

    // Store widths
    localparam logic [1:0] STORE_B = 2'b00;
    localparam logic [1:0] STORE_H = 2'b01;
    localparam logic [1:0] STORE_W = 2'b10;

    // Branch conditions
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Decoded control fields carried from ID into EX
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic [1:0] store_type;
        logic [2:0] load_type;
        logic [2:0] branch_cond;
    } ctrl_t;

    // Only U-type and JAL carry no rs1 field
    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    // Only R-type, stores and branches read rs2
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] e_rd,
    input  logic [1:0] e_result_src,
    input  logic       e_valid,
    output logic       load_use
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a dependency and a bubble in EX never loads anything
    always_comb begin
        ex_is_load = e_valid && (e_result_src == RES_SRC_MEM) && (e_rd != 5'd0);
        rs1_hit    = uses_rs1(opcode) && (rs1 == e_rd);
        rs2_hit    = uses_rs2(opcode) && (rs2 == e_rd);
        load_use   = ex_is_load && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall/bubble, EX flush, MEM hold and a bubble counter.
module id_ex_stage_reg
    import rv32_pkg::*;
#(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_e,
    input  logic             hold_e,
    input  logic [6:0]       d_opcode,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic [4:0]       d_rd,
    input  logic [XLEN-1:0]  d_rs1_data,
    input  logic [XLEN-1:0]  d_rs2_data,
    input  logic [XLEN-1:0]  d_imm,
    input  logic [XLEN-1:0]  d_pc,
    input  logic [XLEN-1:0]  d_pc4,
    input  logic             d_reg_write,
    input  logic             d_mem_write,
    input  logic             d_jump,
    input  logic             d_branch,
    input  logic             d_alu_src,
    input  logic [1:0]       d_result_src,
    input  logic [3:0]       d_alu_ctrl,
    input  logic [1:0]       d_store_type,
    input  logic [2:0]       d_load_type,
    input  logic [2:0]       d_branch_cond,
    output logic [4:0]       e_rs1,
    output logic [4:0]       e_rs2,
    output logic [4:0]       e_rd,
    output logic [XLEN-1:0]  e_rs1_data,
    output logic [XLEN-1:0]  e_rs2_data,
    output logic [XLEN-1:0]  e_imm,
    output logic [XLEN-1:0]  e_pc,
    output logic [XLEN-1:0]  e_pc4,
    output logic             e_reg_write,
    output logic             e_mem_write,
    output logic             e_jump,
    output logic             e_branch,
    output logic             e_alu_src,
    output logic [1:0]       e_result_src,
    output logic [3:0]       e_alu_ctrl,
    output logic [1:0]       e_store_type,
    output logic [2:0]       e_load_type,
    output logic [2:0]       e_branch_cond,
    output logic             e_valid,
    output logic             stall_f,
    output logic             stall_d,
    output logic [CNT_W-1:0] bubble_count
);

    ctrl_t            ctrl_reg;
    ctrl_t            d_ctrl;
    logic [4:0]       rs1_reg;
    logic [4:0]       rs2_reg;
    logic [4:0]       rd_reg;
    logic [XLEN-1:0]  rs1_data_reg;
    logic [XLEN-1:0]  rs2_data_reg;
    logic [XLEN-1:0]  imm_reg;
    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  pc4_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] bubble_count_reg;
    logic             load_use;
    logic             stall_next;

    load_use_detect u_load_use_detect (
        .opcode       (d_opcode),
        .rs1          (d_rs1),
        .rs2          (d_rs2),
        .e_rd         (rd_reg),
        .e_result_src (ctrl_reg.result_src),
        .e_valid      (valid_reg),
        .load_use     (load_use)
    );

    // Gather decoded controls into one bundle for a single capture assignment
    always_comb begin
        d_ctrl             = '0;
        d_ctrl.reg_write   = d_reg_write;
        d_ctrl.mem_write   = d_mem_write;
        d_ctrl.jump        = d_jump;
        d_ctrl.branch      = d_branch;
        d_ctrl.alu_src     = d_alu_src;
        d_ctrl.result_src  = d_result_src;
        d_ctrl.alu_ctrl    = d_alu_ctrl;
        d_ctrl.store_type  = d_store_type;
        d_ctrl.load_type   = d_load_type;
        d_ctrl.branch_cond = d_branch_cond;
    end

    // Freeze IF/ID only when the bubble will actually be inserted this edge
    always_comb begin
        stall_next = load_use && !flush_e && !hold_e && !rst;
    end

    // Priority: reset, flush (bubble), hold (keep), load-use (bubble + count), capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg         <= '0;
            rs1_reg          <= '0;
            rs2_reg          <= '0;
            rd_reg           <= '0;
            rs1_data_reg     <= '0;
            rs2_data_reg     <= '0;
            imm_reg          <= '0;
            pc_reg           <= '0;
            pc4_reg          <= '0;
            valid_reg        <= 1'b0;
            bubble_count_reg <= '0;
        end else if (flush_e || (!hold_e && load_use)) begin
            // A bubble is an all-zero slot; alu_ctrl zero is ADD
            ctrl_reg     <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
            pc_reg       <= '0;
            pc4_reg      <= '0;
            valid_reg    <= 1'b0;
            if (!flush_e) begin
                bubble_count_reg <= bubble_count_reg + CNT_W'(1);
            end
        end else if (!hold_e) begin
            ctrl_reg     <= d_ctrl;
            rs1_reg      <= d_rs1;
            rs2_reg      <= d_rs2;
            rd_reg       <= d_rd;
            rs1_data_reg <= d_rs1_data;
            rs2_data_reg <= d_rs2_data;
            imm_reg      <= d_imm;
            pc_reg       <= d_pc;
            pc4_reg      <= d_pc4;
            valid_reg    <= 1'b1;
        end
    end

    assign e_rs1         = rs1_reg;
    assign e_rs2         = rs2_reg;
    assign e_rd          = rd_reg;
    assign e_rs1_data    = rs1_data_reg;
    assign e_rs2_data    = rs2_data_reg;
    assign e_imm         = imm_reg;
    assign e_pc          = pc_reg;
    assign e_pc4         = pc4_reg;
    assign e_reg_write   = ctrl_reg.reg_write;
    assign e_mem_write   = ctrl_reg.mem_write;
    assign e_jump        = ctrl_reg.jump;
    assign e_branch      = ctrl_reg.branch;
    assign e_alu_src     = ctrl_reg.alu_src;
    assign e_result_src  = ctrl_reg.result_src;
    assign e_alu_ctrl    = ctrl_reg.alu_ctrl;
    assign e_store_type  = ctrl_reg.store_type;
    assign e_load_type   = ctrl_reg.load_type;
    assign e_branch_cond = ctrl_reg.branch_cond;
    assign e_valid       = valid_reg;
    assign stall_f       = stall_next;
    assign stall_d       = stall_next;
    assign bubble_count  = bubble_count_reg;

endmodule
